// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (double-dabble, one input bit per clock) with start/busy/done handshake.
// Optional build macro BCD_SAT_EN: on overflow bcd_out saturates to all nines instead of truncated low digits.
module bin2bcd_seq #(
  parameter int unsigned BIN_W  = 16,
  parameter int unsigned DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  ovf
);

  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned CNT_W = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [BIN_W-1:0]   bin_q, bin_d;
  logic [BCD_W-1:0]   work_q, work_d;
  logic               ovf_acc_q, ovf_acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_d, done_d, ovf_d;
  logic [BCD_W-1:0]   bcd_d;
  logic [BCD_W-1:0]   adj_c;
  logic [BCD_W-1:0]   result_c;

  // Add-3 correction on every working digit that would exceed 9 after doubling
  always_comb begin
    adj_c = work_q;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (work_q[4*i +: 4] >= 4'd5) begin
        adj_c[4*i +: 4] = work_q[4*i +: 4] + 4'd3;
      end
    end
  end

  // Value presented on bcd_out when the conversion completes
`ifdef BCD_SAT_EN
  assign result_c = ovf_acc_q ? {DIGITS{4'h9}} : work_q;
`else
  assign result_c = work_q;
`endif

  // Next-state, datapath and registered-output logic
  always_comb begin
    state_d   = state_q;
    bin_d     = bin_q;
    work_d    = work_q;
    ovf_acc_d = ovf_acc_q;
    cnt_d     = cnt_q;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    bcd_d     = bcd_out;
    ovf_d     = ovf;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = SHIFT;
          bin_d     = bin_in;
          work_d    = '0;
          ovf_acc_d = 1'b0;
          cnt_d     = CNT_W'(BIN_W);
        end
      end

      SHIFT: begin
        busy_d    = 1'b1;
        work_d    = {adj_c[BCD_W-2:0], bin_q[BIN_W-1]};
        bin_d     = bin_q << 1;
        ovf_acc_d = ovf_acc_q | adj_c[BCD_W-1];
        cnt_d     = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
        done_d  = 1'b1;
        bcd_d   = result_c;
        ovf_d   = ovf_acc_q;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, datapath and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      bin_q     <= '0;
      work_q    <= '0;
      ovf_acc_q <= 1'b0;
      cnt_q     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      bcd_out   <= '0;
      ovf       <= 1'b0;
    end else begin
      state_q   <= state_d;
      bin_q     <= bin_d;
      work_q    <= work_d;
      ovf_acc_q <= ovf_acc_d;
      cnt_q     <= cnt_d;
      busy      <= busy_d;
      done      <= done_d;
      bcd_out   <= bcd_d;
      ovf       <= ovf_d;
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: vector tables, random values against a decimal model, handshake corner cases.
module tb_bin2bcd_seq;

`ifdef BCD_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] bin_in = '0;
  logic        busy, done, ovf;
  logic [19:0] bcd_out;
  logic        start4 = 1'b0;
  logic [15:0] bin_in4 = '0;
  logic        busy4, done4, ovf4;
  logic [15:0] bcd4;

  int errors = 0;
  int checks = 0;

  bin2bcd_seq #(.BIN_W(16), .DIGITS(5)) dut (
    .clk(clk), .rst(rst), .start(start), .bin_in(bin_in),
    .busy(busy), .done(done), .bcd_out(bcd_out), .ovf(ovf)
  );

  bin2bcd_seq #(.BIN_W(16), .DIGITS(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .bin_in(bin_in4),
    .busy(busy4), .done(done4), .bcd_out(bcd4), .ovf(ovf4)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] v;
    logic [19:0] bcd;
    logic        ovf;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Decimal reference: digits by repeated division, overflow by comparing against 10^digits
  function automatic logic [39:0] model_bcd(input longint unsigned v, input int digits, input bit sat);
    logic [39:0] r;
    longint unsigned lim;
    longint unsigned x;
    r = '0;
    lim = 1;
    for (int i = 0; i < digits; i++) lim = lim * 10;
    x = v;
    for (int i = 0; i < digits; i++) begin
      r[4*i +: 4] = (sat && v >= lim) ? 4'h9 : 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic bit model_ovf(input longint unsigned v, input int digits);
    longint unsigned lim;
    lim = 1;
    for (int i = 0; i < digits; i++) lim = lim * 10;
    return v >= lim;
  endfunction

  // One conversion on the 5-digit instance with latency, busy width and output hold checks
  task automatic conv5(input logic [15:0] v, input logic [19:0] exp_bcd, input logic exp_ovf, input string nm);
    int busy_cnt, done_at;
    logic [19:0] prev, got;
    logic got_ovf;
    bit held;
    @(negedge clk);
    prev = bcd_out;
    start = 1'b1;
    bin_in = v;
    @(posedge clk);
    #1 start = 1'b0;
    busy_cnt = 0; done_at = -1; held = 1'b1; got = '0; got_ovf = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (busy) busy_cnt++;
      if (done && done_at < 0) begin
        done_at = k; got = bcd_out; got_ovf = ovf;
      end
      if (done_at < 0 && bcd_out !== prev) held = 1'b0;
    end
    check({nm, " done_latency"}, 64'(done_at), 64'(17));
    check({nm, " busy_cycles"}, 64'(busy_cnt), 64'(16));
    check({nm, " bcd"}, 64'(got), 64'(exp_bcd));
    check({nm, " ovf"}, 64'(got_ovf), 64'(exp_ovf));
    check({nm, " hold_during_shift"}, 64'(held), 64'(1));
    check({nm, " hold_after_done"}, 64'(bcd_out), 64'(exp_bcd));
  endtask

  task automatic conv4(input logic [15:0] v, input logic [15:0] exp_bcd, input logic exp_ovf, input string nm);
    int done_at;
    logic [15:0] got;
    logic got_ovf;
    @(negedge clk);
    start4 = 1'b1;
    bin_in4 = v;
    @(posedge clk);
    #1 start4 = 1'b0;
    done_at = -1; got = '0; got_ovf = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (done4 && done_at < 0) begin
        done_at = k; got = bcd4; got_ovf = ovf4;
      end
    end
    check({nm, " done_latency"}, 64'(done_at), 64'(17));
    check({nm, " bcd"}, 64'(got), 64'(exp_bcd));
    check({nm, " ovf"}, 64'(got_ovf), 64'(exp_ovf));
  endtask

  vec_t vec5[9];
  vec_t vec4[5];

  initial begin
    int ndone, d[3];
    logic [19:0] r[3];
    logic [15:0] seq_vals[3];
    logic [15:0] rv;
    bit quiet;

    vec5[0] = '{16'd0,     20'h00000, 1'b0};
    vec5[1] = '{16'd9999,  20'h09999, 1'b0};
    vec5[2] = '{16'd65535, 20'h65535, 1'b0};
    vec5[3] = '{16'd1,     20'h00001, 1'b0};
    vec5[4] = '{16'd10,    20'h00010, 1'b0};
    vec5[5] = '{16'd59,    20'h00059, 1'b0};
    vec5[6] = '{16'd10000, 20'h10000, 1'b0};
    vec5[7] = '{16'd32768, 20'h32768, 1'b0};
    vec5[8] = '{16'd50505, 20'h50505, 1'b0};

    vec4[0] = '{16'd12345, SAT ? 20'h09999 : 20'h02345, 1'b1};
    vec4[1] = '{16'd9999,  20'h09999, 1'b0};
    vec4[2] = '{16'd10000, SAT ? 20'h09999 : 20'h00000, 1'b1};
    vec4[3] = '{16'd65535, SAT ? 20'h09999 : 20'h05535, 1'b1};
    vec4[4] = '{16'd0,     20'h00000, 1'b0};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Idle after reset with no start
    quiet = 1'b1;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      if (busy || done || bcd_out != 20'h0 || ovf || busy4 || done4 || bcd4 != 16'h0 || ovf4) quiet = 1'b0;
    end
    check("reset_idle_quiet", 64'(quiet), 64'(1));

    for (int i = 0; i < 9; i++) conv5(vec5[i].v, vec5[i].bcd, vec5[i].ovf, $sformatf("vec5[%0d]", i));
    for (int i = 0; i < 5; i++) conv4(vec4[i].v, 16'(vec4[i].bcd), vec4[i].ovf, $sformatf("vec4[%0d]", i));

    for (int i = 0; i < 12; i++) begin
      rv = 16'($urandom);
      conv5(rv, 20'(model_bcd(64'(rv), 5, SAT)), model_ovf(64'(rv), 5), $sformatf("rand5_%0d", rv));
      conv4(rv, 16'(model_bcd(64'(rv), 4, SAT)), model_ovf(64'(rv), 4), $sformatf("rand4_%0d", rv));
    end

    // Start pulses during SHIFT and DONE are ignored
    @(negedge clk); start = 1'b1; bin_in = 16'd100;
    @(posedge clk); #1 start = 1'b0;
    ndone = 0; d[0] = -1; r[0] = '0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (done) begin
        ndone++;
        if (d[0] < 0) begin d[0] = k; r[0] = bcd_out; end
      end
      if (k == 3 || k == 16) begin start = 1'b1; bin_in = 16'd200; end
      else start = 1'b0;
    end
    check("ignore_done_count", 64'(ndone), 64'(1));
    check("ignore_done_at", 64'(d[0]), 64'(17));
    check("ignore_bcd", 64'(r[0]), 64'(20'h00100));
    conv5(16'd200, 20'h00200, 1'b0, "after_ignore");

    // Synchronous reset mid-conversion discards the result
    @(negedge clk); start = 1'b1; bin_in = 16'd4321;
    @(posedge clk); #1 start = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_busy", 64'(busy), 64'(0));
    check("midrst_done", 64'(done), 64'(0));
    check("midrst_bcd", 64'(bcd_out), 64'(0));
    check("midrst_ovf", 64'(ovf), 64'(0));
    rst = 1'b0;
    ndone = 0;
    for (int k = 0; k < 25; k++) begin
      @(posedge clk); #1;
      if (done || busy) ndone++;
    end
    check("midrst_no_activity", 64'(ndone), 64'(0));
    conv5(16'd4321, 20'h04321, 1'b0, "after_rst");

    // Start held high: back-to-back conversions every 18 cycles
    seq_vals[0] = 16'd7; seq_vals[1] = 16'd42; seq_vals[2] = 16'd1000;
    @(negedge clk); start = 1'b1; bin_in = seq_vals[0];
    ndone = 0;
    for (int i = 0; i < 3; i++) begin d[i] = -1; r[i] = '0; end
    for (int k = 0; k < 80; k++) begin
      @(posedge clk); #1;
      if (done && ndone < 3) begin
        d[ndone] = k; r[ndone] = bcd_out;
        ndone++;
        if (ndone < 3) bin_in = seq_vals[ndone];
        else start = 1'b0;
      end
    end
    start = 1'b0;
    check("held_done_count", 64'(ndone), 64'(3));
    check("held_first_latency", 64'(d[0]), 64'(17));
    check("held_spacing_1", 64'(d[1] - d[0]), 64'(18));
    check("held_spacing_2", 64'(d[2] - d[1]), 64'(18));
    check("held_bcd_0", 64'(r[0]), 64'(20'h00007));
    check("held_bcd_1", 64'(r[1]), 64'(20'h00042));
    check("held_bcd_2", 64'(r[2]), 64'(20'h01000));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
